sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Single-clock, parametrised FIFO; the same-domain companion to cdcfifo for paths with no clock crossing.
//   Arbitrary (non-power-of-two) depth, first-word-fall-through read port, occupancy count, almost-full/empty flags.
//   Sits between a producer and consumer on one clock, with the same valid/ready naming as cdcfifo.
// PARAMETERS
//   FIFO_WIDTH     8    data width in bits
//   FIFO_DEPTH     255  number of entries, >=2, any integer (not restricted to 2^n)
//   AFULL_THRESH   240  almostFull asserted when fillCount >= AFULL_THRESH (1..FIFO_DEPTH)
//   AEMPTY_THRESH  15   almostEmpty asserted when fillCount <= AEMPTY_THRESH (0..FIFO_DEPTH-1)
// PORTS
//   clk          in   1                         clock, all state on rising edge
//   rst          in   1                         reset, asynchronous, active-high
//   writeValid   in   1                         producer offers writeData this cycle
//   writeData    in   FIFO_WIDTH                write payload
//   writeReady   out  1                         FIFO can accept a write this cycle
//   readValid    in   1                         consumer takes head entry this cycle
//   readData     out  FIFO_WIDTH                head entry (FWFT); valid only while readReady=1
//   readReady    out  1                         head entry available
//   fillCount    out  $clog2(FIFO_DEPTH+1)      current occupancy
//   almostFull   out  1                         fillCount >= AFULL_THRESH
//   almostEmpty  out  1                         fillCount <= AEMPTY_THRESH
//   dropCount    out  16                        overwritten entries (only with SYNC_FIFO_DROP_OLDEST_EN)
// BEHAVIOUR
//   - Write accepted: writeValid && writeReady. Read accepted: readValid && readReady.
//   - writeReady = (fillCount != FIFO_DEPTH); readReady = (fillCount != 0); both decoded from registered count.
//   - wrPtr/rdPtr range 0..FIFO_DEPTH-1; explicit wrap FIFO_DEPTH-1 -> 0 (no power-of-two masking).
//   - fillCount: +1 write only, -1 read only, unchanged on both or neither.
//   - readData = mem[rdPtr]; write-to-readReady latency 1 cycle (write at edge N, readReady high after edge N).
//   - No write-through: empty FIFO with same-cycle write gives readReady=0 that cycle.
//   - Full + readValid + writeValid: read accepted, write stalled (writeReady=0); count -> FIFO_DEPTH-1.
//   - Empty + readValid: ignored, no pointer/count change. Full + writeValid: data held by producer, not stored.
//   - almostFull/almostEmpty combinational from registered fillCount.
//   - Reset (any time, no clock edge needed): wrPtr=rdPtr=0, fillCount=0, writeReady=1, readReady=0,
//     almostFull=0, almostEmpty=1, dropCount=0; storage array not reset, contents discarded.
//   - Elaboration: $error if FIFO_DEPTH<2 or thresholds out of range.
// CONFIGURATION
//   SYNC_FIFO_DROP_OLDEST_EN defined (overwrite mode):
//     - writeReady tied 1. Write when full: store at wrPtr, advance wrPtr and rdPtr, fillCount stays FIFO_DEPTH,
//       dropCount += 1, saturating at 16'hFFFF.
//     - Full + accepted read + write: normal read, no drop, count unchanged.
//   SYNC_FIFO_DROP_OLDEST_EN undefined: dropCount port absent; normal backpressure as above.
// TESTING  (FIFO_DEPTH=5, AFULL_THRESH=4, AEMPTY_THRESH=1, FIFO_WIDTH=8)
//   1 rst=1 for 3 clk, then low -> writeReady=1, readReady=0, fillCount=0, almostEmpty=1, almostFull=0.
//   2 write 0x10..0x14 back-to-back -> fillCount=4 gives almostFull=1; after 5th write writeReady=0;
//     6th write 0x15 held 4 cycles -> fillCount stays 5, 0x15 not stored.
//   3 drain 5 reads -> readData 0x10,0x11,0x12,0x13,0x14 in order; readReady=0 after 5th; extra read no change.
//   4 at fillCount=3 drive read+write every cycle for 12 cycles -> fillCount stays 3, pointers wrap 4->0,
//     output order equals input order.
//   5 fillCount=3, assert rst between clk edges -> all outputs at reset values before next edge;
//     after release, first write 0x55 read back as 0x55.
//   6 with SYNC_FIFO_DROP_OLDEST_EN: fill 0x10..0x14, write 0xAA -> writeReady=1, dropCount=1,
//     readData=0x11; drain gives 0x11,0x12,0x13,0x14,0xAA.

Source files
------------

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with arbitrary depth, first-word-fall-through
// read port, occupancy count and almost-full/almost-empty flags.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   writeValid   producer offers writeData          writeReady  FIFO can take a write
//   readValid    consumer takes the head entry      readReady   head entry available
//   readData     head entry, valid while readReady = 1
//   fillCount    current occupancy (0..FIFO_DEPTH)
//   almostFull   fillCount >= AFULL_THRESH          almostEmpty fillCount <= AEMPTY_THRESH
//   dropCount    overwritten-entry count, saturating (only with SYNC_FIFO_DROP_OLDEST_EN)
//
// Build option: define SYNC_FIFO_DROP_OLDEST_EN for overwrite mode, where a write into a
// full FIFO replaces the oldest entry instead of being backpressured.

module sync_fifo_param #(
    parameter int unsigned FIFO_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 255,
    parameter int unsigned AFULL_THRESH  = 240,
    parameter int unsigned AEMPTY_THRESH = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            writeValid,
    input  logic [FIFO_WIDTH-1:0]           writeData,
    output logic                            writeReady,
    input  logic                            readValid,
    output logic [FIFO_WIDTH-1:0]           readData,
    output logic                            readReady,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fillCount,
    output logic                            almostFull,
`ifdef SYNC_FIFO_DROP_OLDEST_EN
    output logic                            almostEmpty,
    output logic [15:0]                     dropCount
`else
    output logic                            almostEmpty
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    // Parameter sanity checks at elaboration
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_param: FIFO_DEPTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
        $error("sync_fifo_param: AFULL_THRESH must be in 1..FIFO_DEPTH");
    end
    if (AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_param: AEMPTY_THRESH must be in 0..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;
    logic                  drop;

    // Explicit wrap so non-power-of-two depths index correctly
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status decoded from the registered count
    always_comb begin
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        readReady   = (count_q != '0);
        fillCount   = count_q;
        almostFull  = (count_q >= CNT_W'(AFULL_THRESH));
        almostEmpty = (count_q <= CNT_W'(AEMPTY_THRESH));
        readData    = mem_q[rd_ptr_q];
`ifdef SYNC_FIFO_DROP_OLDEST_EN
        writeReady  = 1'b1;
`else
        writeReady  = !full;
`endif
        wr_en       = writeValid && writeReady;
        rd_en       = readValid && readReady;
        // Overwrite of the oldest entry only when full and nothing is read this cycle
`ifdef SYNC_FIFO_DROP_OLDEST_EN
        drop        = wr_en && full && !rd_en;
`else
        drop        = 1'b0;
`endif
    end

    // Pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_en || drop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (wr_en && !rd_en && !drop) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; contents are meaningless until written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= writeData;
        end
    end

`ifdef SYNC_FIFO_DROP_OLDEST_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of overwritten entries
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropCount = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=5, AFULL=4, AEMPTY=1, WIDTH=8).
// Stimulus drives inputs 1 time unit after the rising edge; a negedge monitor keeps a
// reference queue of accepted writes and compares status and head data.

module tb_sync_fifo_param;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned AF    = 4;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef SYNC_FIFO_DROP_OLDEST_EN
    localparam bit DROP_MODE = 1'b1;
`else
    localparam bit DROP_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          writeValid;
    logic [W-1:0]  writeData;
    logic          writeReady;
    logic          readValid;
    logic [W-1:0]  readData;
    logic          readReady;
    logic [CW-1:0] fillCount;
    logic          almostFull;
    logic          almostEmpty;
`ifdef SYNC_FIFO_DROP_OLDEST_EN
    logic [15:0]   dropCount;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb[$];

    sync_fifo_param #(
        .FIFO_WIDTH   (W),
        .FIFO_DEPTH   (DEPTH),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .writeValid (writeValid),
        .writeData  (writeData),
        .writeReady (writeReady),
        .readValid  (readValid),
        .readData   (readData),
        .readReady  (readReady),
        .fillCount  (fillCount),
        .almostFull (almostFull),
`ifdef SYNC_FIFO_DROP_OLDEST_EN
        .almostEmpty(almostEmpty),
        .dropCount  (dropCount)
`else
        .almostEmpty(almostEmpty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_writeReady", 32'(writeReady), 32'd1);
        chk("rst_readReady", 32'(readReady), 32'd0);
        chk("rst_fillCount", 32'(fillCount), 32'd0);
        chk("rst_almostEmpty", 32'(almostEmpty), 32'd1);
        chk("rst_almostFull", 32'(almostFull), 32'd0);
`ifdef SYNC_FIFO_DROP_OLDEST_EN
        chk("rst_dropCount", 32'(dropCount), 32'd0);
`endif
    endtask

    // Reference model: status compare, then apply the transfer that the next edge will take
    always @(negedge clk) begin
        if (!rst) begin
            int  sz;
            bit  full;
            bit  rd_acc;
            sz     = sb.size();
            full   = (sz == DEPTH);
            rd_acc = readValid && (sz != 0);
            chk("mon_fillCount", 32'(fillCount), 32'(sz));
            chk("mon_readReady", 32'(readReady), 32'(sz != 0));
            chk("mon_writeReady", 32'(writeReady), 32'(DROP_MODE || !full));
            chk("mon_almostFull", 32'(almostFull), 32'(sz >= AF));
            chk("mon_almostEmpty", 32'(almostEmpty), 32'(sz <= AE));
            if (readValid && readReady) begin
                if (sz == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_underflow: got readReady=1 expected 0 at %0t", $time);
                end else begin
                    chk("mon_readData", 32'(readData), 32'(sb.pop_front()));
                end
            end
            if (writeValid && (!full || DROP_MODE)) begin
                if (full && !rd_acc) begin
                    void'(sb.pop_front());
                end
                sb.push_back(writeData);
            end
        end
    end

    initial begin
        logic [W-1:0] exp_tail[3];
        logic [W-1:0] exp_drop[5];
        exp_tail = '{8'h49, 8'h4A, 8'h4B};
        exp_drop = '{8'h11, 8'h12, 8'h13, 8'h14, 8'hAA};

        // 1: reset
        rst        = 1'b1;
        writeValid = 1'b0;
        writeData  = '0;
        readValid  = 1'b0;
        repeat (3) tick();
        chk_reset_outputs();
        rst = 1'b0;
        tick();

`ifndef SYNC_FIFO_DROP_OLDEST_EN
        // 2: fill to full, then hold an extra write against backpressure
        for (int i = 0; i < 5; i++) begin
            writeValid = 1'b1;
            writeData  = W'(8'h10 + i);
            if (i == 0) chk("nowt_readReady", 32'(readReady), 32'd0);
            tick();
            if (i == 0) begin
                chk("lat_readReady", 32'(readReady), 32'd1);
                chk("lat_fillCount", 32'(fillCount), 32'd1);
            end
            if (i == 3) begin
                chk("fill4_count", 32'(fillCount), 32'd4);
                chk("fill4_almostFull", 32'(almostFull), 32'd1);
            end
        end
        chk("full_writeReady", 32'(writeReady), 32'd0);
        writeData = 8'h15;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_fillCount", 32'(fillCount), 32'd5);
        end
        writeValid = 1'b0;

        // 3: drain in order, then an ignored read on empty
        for (int i = 0; i < 5; i++) begin
            readValid = 1'b1;
            chk("drain_readData", 32'(readData), 32'h10 + 32'(i));
            tick();
        end
        chk("drained_readReady", 32'(readReady), 32'd0);
        tick();
        chk("empty_read_fillCount", 32'(fillCount), 32'd0);
        chk("empty_read_writeReady", 32'(writeReady), 32'd1);
        readValid = 1'b0;

        // 4: steady read+write at fillCount=3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            writeValid = 1'b1;
            writeData  = W'(8'h30 + i);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            writeValid = 1'b1;
            readValid  = 1'b1;
            writeData  = W'(8'h40 + i);
            tick();
            chk("steady_fillCount", 32'(fillCount), 32'd3);
        end
        writeValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            readValid = 1'b1;
            chk("steady_tail", 32'(readData), 32'(exp_tail[i]));
            tick();
        end
        readValid = 1'b0;
        chk("steady_empty", 32'(readReady), 32'd0);

        // 5: asynchronous reset mid-cycle with data held, then reuse
        for (int i = 0; i < 3; i++) begin
            writeValid = 1'b1;
            writeData  = W'(8'h60 + i);
            tick();
        end
        writeValid = 1'b0;
        chk("pre_rst_fillCount", 32'(fillCount), 32'd3);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk_reset_outputs();
        tick();
        rst = 1'b0;
        writeValid = 1'b1;
        writeData  = 8'h55;
        tick();
        writeValid = 1'b0;
        readValid  = 1'b1;
        chk("post_rst_readData", 32'(readData), 32'h55);
        tick();
        readValid = 1'b0;
        chk("post_rst_empty", 32'(fillCount), 32'd0);
`else
        // 6: overwrite-oldest mode
        for (int i = 0; i < 5; i++) begin
            writeValid = 1'b1;
            writeData  = W'(8'h10 + i);
            tick();
        end
        writeData = 8'hAA;
        chk("drop_writeReady", 32'(writeReady), 32'd1);
        tick();
        writeValid = 1'b0;
        chk("drop_dropCount", 32'(dropCount), 32'd1);
        chk("drop_readData", 32'(readData), 32'h11);
        chk("drop_fillCount", 32'(fillCount), 32'd5);
        for (int i = 0; i < 5; i++) begin
            readValid = 1'b1;
            chk("drop_drain", 32'(readData), 32'(exp_drop[i]));
            tick();
        end
        readValid = 1'b0;
        chk("drop_empty", 32'(readReady), 32'd0);
        chk("drop_dropCount_end", 32'(dropCount), 32'd1);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
